// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down/bounce counter with a registered terminal-count pulse.
// Optional feature: define PRESCALE_EN to advance only on every PS-th qualifying cycle.
module prog_mod_counter #(
  parameter int W  = 4,
  parameter int PS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] mod_val,
  input  logic [1:0]   mode,
  output logic [W-1:0] count,
  output logic         dir,
  output logic         at_max,
  output logic         tc
);

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_HOLD   = 2'b11
  } mode_e;

  mode_e        mode_q;
  logic [W-1:0] term;
  logic         qual;
  logic         adv;
  logic [W-1:0] count_n;
  logic         dir_n;
  logic         tc_n;

  assign mode_q = mode_e'(mode);
  // mod_val=0 wraps to all-ones, which is exactly 2^W-1
  assign term   = mod_val - W'(1);
  assign at_max = (count == term);
  assign qual   = en & ~load & (mode_q != M_HOLD);

`ifdef PRESCALE_EN
  localparam int PW = (PS > 1) ? $clog2(PS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PS - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk) begin
    if (rst || load) pre <= '0;
    else if (qual)   pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
  end

  assign adv = qual & (pre == PRE_LAST);
`else
  assign adv = qual;
`endif

  always_comb begin
    count_n = count;
    dir_n   = dir;
    tc_n    = 1'b0;
    if (load) begin
      count_n = load_val;
    end else if (adv) begin
      case (mode_q)
        M_UP: begin
          dir_n = 1'b0;
          if (count < term) count_n = count + W'(1);
          else begin
            count_n = '0;
            tc_n    = 1'b1;
          end
        end
        M_DOWN: begin
          dir_n = 1'b1;
          if (count > term) count_n = term;
          else if (count == '0) begin
            count_n = term;
            tc_n    = 1'b1;
          end else count_n = count - W'(1);
        end
        M_BOUNCE: begin
          if (!dir) begin
            if (count < term) count_n = count + W'(1);
            else begin
              // out-of-range counts clamp to T at the turnaround
              count_n = term;
              dir_n   = 1'b1;
              tc_n    = 1'b1;
            end
          end else begin
            if (count > term) count_n = term;
            else if (count == '0) begin
              dir_n = 1'b0;
              tc_n  = 1'b1;
            end else count_n = count - W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dir   <= 1'b0;
      tc    <= 1'b0;
    end else begin
      count <= count_n;
      dir   <= dir_n;
      tc    <= tc_n;
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter: directed vector table, hand sequences, random vs. reference model.
module tb_prog_mod_counter;
  localparam int W  = 4;
  localparam int PS = 3;

  logic         clk = 1'b0;
  logic         rst, en, load;
  logic [W-1:0] load_val, mod_val;
  logic [1:0]   mode;
  logic [W-1:0] count;
  logic         dir, at_max, tc;

  int tests = 0;
  int fails = 0;

  prog_mod_counter #(.W(W), .PS(PS)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .mod_val(mod_val), .mode(mode), .count(count), .dir(dir),
    .at_max(at_max), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, en, load;
    int       lv, mv, md;
    int       e_cnt;
    bit       e_dir, e_tc, e_max;
  } vec_t;

  vec_t vq[$];

  // reference model state
  int  m_cnt, m_dir, m_tc, m_pre;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input bit e, input bit l, input int lv, input int mv,
                     input int md, input int c, input bit d, input bit t, input bit mx);
    vq.push_back('{r, e, l, lv, mv, md, c, d, t, mx});
  endtask

  task automatic drive(input bit r, input bit e, input bit l, input int lv, input int mv,
                       input int md);
    rst = r; en = e; load = l;
    load_val = W'(lv); mod_val = W'(mv); mode = 2'(md);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural next-state from the counting rules, using plain integers.
  task automatic model_step(input bit r, input bit e, input bit l, input int lv, input int mv,
                            input int md);
    int  t;
    bit  go;
    t = ((mv == 0) ? (1 << W) : mv) - 1;
    if (r) begin
      m_cnt = 0; m_dir = 0; m_tc = 0; m_pre = 0;
    end else if (l) begin
      m_cnt = lv; m_tc = 0; m_pre = 0;
    end else begin
      m_tc = 0;
      go   = e && (md != 3);
`ifdef PRESCALE_EN
      if (go) begin
        if (m_pre == PS - 1) m_pre = 0;
        else begin
          m_pre = m_pre + 1;
          go    = 0;
        end
      end
`endif
      if (go) begin
        if (md == 0) begin
          m_dir = 0;
          if (m_cnt < t) m_cnt++;
          else begin m_cnt = 0; m_tc = 1; end
        end else if (md == 1) begin
          m_dir = 1;
          if (m_cnt > t) m_cnt = t;
          else if (m_cnt == 0) begin m_cnt = t; m_tc = 1; end
          else m_cnt--;
        end else if (m_dir == 0) begin
          if (m_cnt < t) m_cnt++;
          else begin m_cnt = t; m_dir = 1; m_tc = 1; end
        end else begin
          if (m_cnt > t) m_cnt = t;
          else if (m_cnt == 0) begin m_dir = 0; m_tc = 1; end
          else m_cnt--;
        end
      end
    end
  endtask

  initial begin
    int mv_r, md_r, t;
    drive(1, 0, 0, 0, 6, 0);

`ifndef PRESCALE_EN
    //  rst en ld lv mv md   cnt dir tc max
    add(1, 0, 0, 0, 6, 0,    0, 0, 0, 0);
    add(0, 1, 0, 0, 6, 0,    1, 0, 0, 0);
    add(0, 1, 0, 0, 6, 0,    2, 0, 0, 0);
    add(0, 1, 0, 0, 6, 0,    3, 0, 0, 0);
    add(0, 1, 0, 0, 6, 0,    4, 0, 0, 0);
    add(0, 1, 0, 0, 6, 0,    5, 0, 0, 1);
    add(0, 1, 0, 0, 6, 0,    0, 0, 1, 0);
    add(0, 1, 0, 0, 6, 0,    1, 0, 0, 0);
    add(0, 1, 0, 0, 5, 1,    0, 1, 0, 0);
    add(0, 1, 0, 0, 5, 1,    4, 1, 1, 1);
    add(0, 1, 0, 0, 5, 1,    3, 1, 0, 0);
    add(0, 1, 0, 0, 5, 3,    3, 1, 0, 0);
    add(0, 0, 0, 0, 5, 0,    3, 1, 0, 0);
    add(0, 1, 1, 9, 0, 0,    9, 1, 0, 0);
    add(0, 1, 0, 0, 6, 0,    0, 0, 1, 0);
    add(0, 1, 0, 0, 4, 2,    1, 0, 0, 0);
    add(0, 1, 0, 0, 4, 2,    2, 0, 0, 0);
    add(0, 1, 0, 0, 4, 2,    3, 0, 0, 1);
    add(0, 1, 0, 0, 4, 2,    3, 1, 1, 1);
    add(0, 1, 0, 0, 4, 2,    2, 1, 0, 0);
    add(0, 1, 0, 0, 4, 2,    1, 1, 0, 0);
    add(0, 1, 0, 0, 4, 2,    0, 1, 0, 0);
    add(0, 1, 0, 0, 4, 2,    0, 0, 1, 0);
    add(0, 1, 0, 0, 4, 2,    1, 0, 0, 0);
    add(0, 0, 1, 14, 4, 2,  14, 0, 0, 0);
    add(0, 1, 0, 0, 4, 2,    3, 1, 1, 1);
    add(0, 1, 1, 12, 4, 2,  12, 1, 0, 0);
    add(0, 1, 0, 0, 4, 2,    3, 1, 0, 1);
    add(0, 1, 1, 10, 4, 1,  10, 1, 0, 0);
    add(0, 1, 0, 0, 4, 1,    3, 1, 0, 1);
    add(0, 1, 0, 0, 1, 2,    0, 1, 0, 1);
    add(0, 1, 0, 0, 1, 2,    0, 0, 1, 1);
    add(0, 1, 0, 0, 1, 2,    0, 1, 1, 1);
    add(0, 1, 0, 0, 1, 2,    0, 0, 1, 1);
    add(0, 1, 1, 7, 8, 2,    7, 0, 0, 1);
    add(0, 1, 0, 0, 8, 2,    7, 1, 1, 1);
    add(1, 1, 0, 0, 8, 2,    0, 0, 0, 0);
    add(0, 1, 1, 15, 0, 0,  15, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,    0, 0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].en, vq[i].load, vq[i].lv, vq[i].mv, vq[i].md);
      cycle();
      check($sformatf("vec%0d.count", i), int'(count), vq[i].e_cnt);
      check($sformatf("vec%0d.dir", i), int'(dir), int'(vq[i].e_dir));
      check($sformatf("vec%0d.tc", i), int'(tc), int'(vq[i].e_tc));
      check($sformatf("vec%0d.at_max", i), int'(at_max), int'(vq[i].e_max));
    end

    // rst pulsed and released between edges must not reset anything
    @(negedge clk);
    drive(0, 0, 1, 7, 8, 2);
    cycle();
    check("glitch.load", int'(count), 7);
    @(negedge clk);
    drive(0, 0, 0, 0, 8, 2);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    cycle();
    check("glitch.count", int'(count), 7);
`else
    // prescaled stepping: every 3rd qualifying cycle; en gaps stretch the step
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    check("pre.rst", int'(count), 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 0, 0);
      cycle();
      check($sformatf("pre.step%0d", k), int'(count), (k == 3) ? 1 : 0);
    end
    for (int k = 4; k <= 8; k++) begin
      @(negedge clk);
      drive(0, (k == 5 || k == 6) ? 1'b0 : 1'b1, 0, 0, 0, 0);
      cycle();
      check($sformatf("pre.gap%0d", k), int'(count), (k == 8) ? 2 : 1);
    end
`endif

    // randomized run against the reference model
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    cycle();
    check("rand.rst", int'(count), m_cnt);
    mv_r = 6;
    md_r = 0;
    for (int i = 0; i < 2000; i++) begin
      bit r, e, l;
      int lv;
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) mv_r = int'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 7) == 0)  md_r = int'($urandom_range(0, 3));
      r  = ($urandom_range(0, 49) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      lv = int'($urandom_range(0, (1 << W) - 1));
      drive(r, e, l, lv, mv_r, md_r);
      model_step(r, e, l, lv, mv_r, md_r);
      cycle();
      t = ((mv_r == 0) ? (1 << W) : mv_r) - 1;
      check("rand.count", int'(count), m_cnt);
      check("rand.dir", int'(dir), m_dir);
      check("rand.tc", int'(tc), m_tc);
      check("rand.at_max", int'(at_max), (m_cnt == t) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 Parameter W, default 4: counter width in bits, W >= 2.
REQ-002 Parameter PS, default 4: prescale divisor, PS >= 1; used only when PRESCALE_EN is defined.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; count advances only on cycles with en=1.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  W  value written to count on load.
REQ-008 mod_val  input  W  runtime modulus M; 0 means 2^W.
REQ-009 mode  input  2  counting mode: 00 up, 01 down, 10 bounce, 11 hold.
REQ-010 count  output  W  current count, registered.
REQ-011 dir  output  1  current direction, registered; 0 up, 1 down.
REQ-012 at_max  output  1  combinational, count == T.
REQ-013 tc  output  1  registered terminal-count pulse, one cycle.

Function
REQ-014 Terminal value T SHALL be mod_val-1, or 2^W-1 when mod_val=0; mod_val=1 gives T=0.
REQ-015 Priority per cycle SHALL be rst > load > advance > hold.
REQ-016 load=1 SHALL set count=load_val, leave dir unchanged, clear tc, and ignore en.
REQ-017 Advance SHALL occur on cycles with en=1, load=0, mode!=11 (subject to REQ-028).
REQ-018 Up mode, advance: count<T -> count+1; count>=T -> 0 and tc=1 next cycle; dir forced 0.
REQ-019 Down mode, advance: count>T -> T; 0<count<=T -> count-1; count=0 -> T and tc=1; dir forced 1.
REQ-020 Bounce mode, dir=0: count<T -> +1; count>=T -> count=T, dir=1, tc=1.
REQ-021 Bounce mode, dir=1: count>T -> T; 0<count<=T -> -1; count=0 -> dir=0, tc=1, count stays 0.
REQ-022 Bounce with T=0: count stays 0, dir toggles, and tc=1 on every advance.
REQ-023 Hold mode, or en=0: count and dir SHALL be unchanged, and tc=0.
REQ-024 tc SHALL be high exactly one cycle after each wrap/turnaround advance and low otherwise.
REQ-025 A mod_val or mode change SHALL take effect on the next edge without a reset; an out-of-range count is resolved per REQ-018..021.
REQ-026 All arithmetic SHALL be modulo 2^W with no overflow beyond W bits.

Reset
REQ-027 On rst=1 at a clock edge: count=0, dir=0, tc=0, prescaler=0; at_max then reflects T==0.

Configuration
REQ-028 Macro PRESCALE_EN defined: advance SHALL occur only on every PS-th qualifying cycle, tracked by an internal 0..PS-1 counter.
REQ-029 With PRESCALE_EN, the prescaler SHALL increment only on qualifying cycles, clear on rst and load, and hold on en=0 or hold mode.
REQ-030 Without PRESCALE_EN, every qualifying cycle SHALL advance, PS SHALL be ignored, and no prescaler logic SHALL be synthesised.

Verification
REQ-031 W=4, mod_val=6, mode=00, en=1 held for 12 cycles from reset -> count 0..5,0..5; tc high the cycle after each 5->0; at_max high at 5.
REQ-032 mod_val=5, mode=01, from reset -> count 4,3,2,1,0,4; tc after the 0->4 step; dir=1.
REQ-033 mod_val=4, mode=10 -> count 0,1,2,3,2,1,0,1; dir toggles at 3 and at 0; tc pulses at each turnaround.
REQ-034 Up mode at count=9, mod_val changed 16->6 -> next count 0, tc=1; load=1 with en=1, load_val=3 -> count 3, tc=0.
REQ-035 PRESCALE_EN, PS=3, mode=00, mod_val=0, en=1 -> count steps every 3rd cycle; en low for 2 cycles mid-prescale delays the step by exactly 2 cycles.
REQ-036 rst=1 asserted mid-bounce with dir=1, count=7 -> next edge count=0, dir=0, tc=0; rst not sampled between edges has no effect.
